// File: rtl/branch_redirect_ctl.sv
// Branch redirect controller: turns a taken MEM-stage branch into pipeline flushes plus a
// held redirect request to fetch. Define BRANCH_REDIRECT_STATS_EN to add the statistics counters.
module branch_redirect_ctl #(
    parameter int PC_WIDTH      = 32,
    parameter int REFILL_CYCLES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                mem_valid_i,
    input  logic                taken_i,
    input  logic [PC_WIDTH-1:0] target_pc_i,
    output logic                redirect_valid_o,
    output logic [PC_WIDTH-1:0] redirect_pc_o,
    input  logic                redirect_ready_i,
    output logic                flush_if_o,
    output logic                flush_id_o,
    output logic                flush_ex_o,
    output logic                stall_o,
    output logic                busy_o,
    output logic [1:0]          dbg_state_o
`ifdef BRANCH_REDIRECT_STATS_EN
    ,
    output logic [31:0]         taken_cnt_o,
    output logic [31:0]         stall_cnt_o
`endif
);

    // Handshake: the redirect is transferred on a rising edge where redirect_valid_o and
    // redirect_ready_i are both 1; valid and redirect_pc_o stay fixed until that edge.

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_REFILL   = 2'd2
    } state_t;

    localparam logic [3:0] REFILL_LOAD = (REFILL_CYCLES > 0) ? 4'(REFILL_CYCLES - 1) : 4'd0;

    state_t              state;
    logic [3:0]          refill_cnt;
    logic [PC_WIDTH-1:0] target_q;
    logic                accept;

    // A branch resolving while a redirect is already pending is wrong-path and is ignored.
    assign accept = mem_valid_i & taken_i & (state != S_REDIRECT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            refill_cnt <= 4'd0;
            target_q   <= '0;
        end else if (accept) begin
            target_q <= target_pc_i;
            state    <= S_REDIRECT;
        end else begin
            case (state)
                S_REDIRECT: begin
                    if (redirect_ready_i) begin
                        if (REFILL_CYCLES == 0) begin
                            state <= S_IDLE;
                        end else begin
                            state      <= S_REFILL;
                            refill_cnt <= REFILL_LOAD;
                        end
                    end
                end
                S_REFILL: begin
                    if (refill_cnt == 4'd0) begin
                        state <= S_IDLE;
                    end else begin
                        refill_cnt <= refill_cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign redirect_valid_o = (state == S_REDIRECT);
    assign stall_o          = (state == S_REDIRECT);
    assign busy_o           = (state != S_IDLE);
    assign redirect_pc_o    = target_q;
    assign flush_if_o       = accept;
    assign flush_id_o       = accept;
    assign flush_ex_o       = accept;
    assign dbg_state_o      = state;

`ifdef BRANCH_REDIRECT_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            taken_cnt_o <= 32'd0;
            stall_cnt_o <= 32'd0;
        end else begin
            if (accept) taken_cnt_o <= taken_cnt_o + 32'd1;
            if (stall_o) stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: doc/branch_redirect_ctl.md
BRANCH_REDIRECT_CTL -- requirements
Module: branch_redirect_ctl

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, width of target/redirect PC.
REQ-002 SHALL have parameter REFILL_CYCLES, default 2, range 0..15, post-redirect cycles before new branches resolve normally.
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mem_valid_i  input  1  MEM-stage instruction valid.
REQ-006 SHALL have port taken_i  input  1  branch-taken flag from MEM-stage branch evaluation.
REQ-007 SHALL have port target_pc_i  input  PC_WIDTH  branch target, sampled with taken_i.
REQ-008 SHALL have port redirect_valid_o  output  1  redirect request to fetch.
REQ-009 SHALL have port redirect_pc_o  output  PC_WIDTH  redirect target.
REQ-010 SHALL have port redirect_ready_i  input  1  fetch accepts redirect.
REQ-011 SHALL have ports flush_if_o, flush_id_o, flush_ex_o  output  1 each  squash the named stage register.
REQ-012 SHALL have port stall_o  output  1  freeze IF/ID while a redirect is pending.
REQ-013 SHALL have port busy_o  output  1  FSM not in IDLE.
REQ-014 SHALL have ports taken_cnt_o and stall_cnt_o  output  32 each  statistics; present only under REQ-031.

Function
REQ-015 SHALL implement FSM states IDLE, REDIRECT, REFILL.
REQ-016 "Accept" SHALL mean mem_valid_i & taken_i in IDLE or REFILL; in REDIRECT, taken_i SHALL be ignored.
REQ-017 On accept, flush_if_o/flush_id_o/flush_ex_o SHALL all be 1 combinationally in that cycle; otherwise 0.
REQ-018 On accept, target_pc_i SHALL be captured and the next state SHALL be REDIRECT.
REQ-019 In REDIRECT: redirect_valid_o=1, stall_o=1, and redirect_pc_o SHALL equal the captured target, stable until handshake.
REQ-020 Handshake SHALL occur when redirect_valid_o & redirect_ready_i at a clock edge; redirect_valid_o SHALL never drop before it.
REQ-021 On handshake: if REFILL_CYCLES=0, next state SHALL be IDLE; else REFILL with counter loaded to REFILL_CYCLES-1.
REQ-022 In REFILL: counter SHALL decrement each cycle; at 0 without accept, next state SHALL be IDLE; redirect_valid_o=0, stall_o=0.
REQ-023 Accept in REFILL SHALL take priority over counter expiry and restart at REQ-017/REQ-018.
REQ-024 busy_o SHALL be 1 in REDIRECT and REFILL.
REQ-025 In IDLE with no accept, all outputs except redirect_pc_o SHALL be 0; redirect_pc_o holds the last captured value.
REQ-026 Minimum accept-to-redirect latency SHALL be 1 cycle (redirect_valid_o high the cycle after accept).

Reset
REQ-027 rst_i SHALL asynchronously force IDLE, counter 0, captured target 0, statistics 0.
REQ-028 During reset: redirect_valid_o, stall_o, busy_o, and all flush outputs SHALL be 0; redirect_pc_o SHALL be 0.
REQ-029 Reset asserted mid-REDIRECT SHALL drop redirect_valid_o immediately with no handshake completed.
REQ-030 First accept SHALL be possible in the first cycle after rst_i deasserts.

Configuration
REQ-031 Macro BRANCH_REDIRECT_STATS_EN defined: taken_cnt_o SHALL increment per accept; stall_cnt_o SHALL increment per cycle with stall_o=1; both wrap modulo 2^32.
REQ-032 Macro undefined: statistics ports and counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Accept with target 0x0000_0100, ready held 1 -> flushes high in cycle T; redirect_valid_o=1 and redirect_pc_o=0x100 in T+1; REFILL in T+2..T+3; IDLE in T+4.
REQ-034 Accept with ready low for 5 cycles -> redirect_valid_o and stall_o high for 6 cycles; redirect_pc_o stable; taken_i pulses during REDIRECT cause no flush.
REQ-035 REFILL_CYCLES=2: second accept (target 0x200) in first REFILL cycle -> flushes, REDIRECT with 0x200; stats taken_cnt_o=2.
REQ-036 taken_i=1 with mem_valid_i=0 in IDLE -> no flush; state remains IDLE.
REQ-037 rst_i asserted mid-REDIRECT -> redirect_valid_o=0 same cycle; after release, IDLE with redirect_pc_o=0.
REQ-038 REFILL_CYCLES=0, ready=1 -> IDLE the cycle after the handshake; stall_cnt_o=1 per redirect.
